// File: rtl/huffman_pkg.sv
// Shared types and constants for the Huffman code bus and the JPEG scan byte stream.
package huffman_pkg;

  localparam int CODE_W = 36;
  localparam int SIZE_W = $clog2(CODE_W + 1);
  localparam int BYTE_W = 8;
  localparam int ACC_W  = 64;

  localparam logic [SIZE_W-1:0] CODE_W_S = SIZE_W'(CODE_W);

  // State encodings kept as plain constants so older tools can match on them.
  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_FLUSH = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  typedef enum logic [1:0] {
    RUN   = ST_RUN,
    FLUSH = ST_FLUSH,
    DONE  = ST_DONE
  } packerState_e;

  typedef struct packed {
    logic [CODE_W-1:0] code;
    logic [SIZE_W-1:0] size;
  } HuffmanData_t;

  typedef struct packed {
    HuffmanData_t data;
    logic         valid;
    logic         done;
  } HuffmanBus_t;

  typedef struct packed {
    logic [BYTE_W-1:0] data;
    logic              valid;
    logic              done;
  } ByteBus_t;

  // Mask keeping only the low 'size' bits of a right-aligned code.
  function automatic logic [CODE_W-1:0] code_mask(input logic [SIZE_W-1:0] size);
    return {CODE_W{1'b1}} >> (CODE_W_S - size);
  endfunction

endpackage

// File: rtl/jpeg_byte_stuffer.sv
// Ready/valid byte stage that inserts a 0x00 after every 0xFF data byte.
module jpeg_byte_stuffer
  import huffman_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [BYTE_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [BYTE_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              stuff_pend_next
);

  logic stuff_pend_q;
  logic stuff_pend_d;

  // While a stuff byte is owed, the raw byte source is held off.
  assign out_valid       = en && (stuff_pend_q || in_valid);
  assign out_data        = stuff_pend_q ? '0 : in_data;
  assign in_ready        = en && !stuff_pend_q && out_ready;
  assign stuff_pend_next = stuff_pend_d;

  // Arm stuffing after a transferred 0xFF, clear it once the 0x00 is transferred.
  always_comb begin
    stuff_pend_d = stuff_pend_q;
    if (out_valid && out_ready) begin
      stuff_pend_d = stuff_pend_q ? 1'b0 : (in_data == 8'hFF);
    end
  end

  // Stuffing flag register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stuff_pend_q <= 1'b0;
    end else begin
      stuff_pend_q <= stuff_pend_d;
    end
  end

endmodule

// File: rtl/huffman_byte_packer.sv
// Packs variable-length Huffman codes MSB-first into a stuffed JPEG scan byte stream.
module huffman_byte_packer
  import huffman_pkg::*;
#(
  parameter int ACC_W = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  HuffmanBus_t in_bus,
  output logic        in_ready,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_done
);

  localparam int CNT_W = $clog2(ACC_W) + 1;
  localparam logic [CNT_W-1:0] READY_MAX = CNT_W'(ACC_W - CODE_W);
  localparam logic [CNT_W-1:0] ACC_BITS  = CNT_W'(ACC_W);
  localparam logic [CNT_W-1:0] BYTE_CNT  = CNT_W'(BYTE_W);

  // Left-aligned bit accumulator: valid bits are acc_q[ACC_W-1 -: cnt_q].
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  packerState_e     state_q, state_d;

  logic              code_take, done_take, pop;
  logic              raw_valid, raw_ready, stream_en, stuff_pend_next;
  logic [SIZE_W-1:0] size_sel;
  logic [ACC_W-1:0]  acc_base, code_ext, pad_ext;
  logic [CNT_W-1:0]  cnt_base, cnt_app, size_eff, pad_n, code_sh, pad_sh;
  logic [2:0]        pad3;
  logic [7:0]        pad_byte;

  assign in_ready  = (state_q == RUN) && (cnt_q <= READY_MAX);
  assign code_take = in_bus.valid && in_ready;
  assign done_take = in_bus.done && in_ready;
  assign stream_en = (state_q != DONE);
  assign raw_valid = stream_en && (cnt_q >= BYTE_CNT);
  assign pop       = raw_valid && raw_ready;
  assign out_done  = (state_q == DONE);

  // Next accumulator: drop a transferred byte, append the code, pad on done, sequence states.
  always_comb begin
    acc_base = pop ? (acc_q << BYTE_W) : acc_q;
    cnt_base = pop ? (cnt_q - BYTE_CNT) : cnt_q;

    // Oversized codes are illegal on the bus; they are dropped rather than corrupting acc.
    size_sel = (code_take && (in_bus.data.size <= CODE_W_S)) ? in_bus.data.size : '0;
    size_eff = CNT_W'(size_sel);
    code_sh  = ACC_BITS - cnt_base - size_eff;
    code_ext = ACC_W'(in_bus.data.code & code_mask(size_sel)) << code_sh;
    cnt_app  = cnt_base + size_eff;

    // Ones fill up to the next byte boundary when the scan closes.
    pad3     = done_take ? (3'd0 - cnt_app[2:0]) : 3'd0;
    pad_n    = CNT_W'(pad3);
    pad_byte = ~(8'hFF << pad3);
    pad_sh   = ACC_BITS - cnt_app - pad_n;
    pad_ext  = ACC_W'(pad_byte) << pad_sh;

    acc_d   = acc_base | code_ext | pad_ext;
    cnt_d   = cnt_app + pad_n;
    state_d = state_q;

    case (state_q)
      RUN: begin
        if (done_take) begin
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        // Leave as soon as the final byte (and any stuff byte) is known to be gone.
        if ((cnt_d == '0) && !stuff_pend_next) begin
          state_d = DONE;
        end
      end
      DONE: begin
        acc_d   = '0;
        cnt_d   = '0;
        state_d = RUN;
      end
      default: begin
        acc_d   = '0;
        cnt_d   = '0;
        state_d = RUN;
      end
    endcase
  end

  // Accumulator, bit count and scan state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q   <= '0;
      cnt_q   <= '0;
      state_q <= RUN;
    end else begin
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
    end
  end

  jpeg_byte_stuffer u_stuffer (
    .clk             (clk),
    .rst_n           (rst_n),
    .en              (stream_en),
    .in_data         (acc_q[ACC_W-1 -: BYTE_W]),
    .in_valid        (raw_valid),
    .in_ready        (raw_ready),
    .out_data        (out_data),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .stuff_pend_next (stuff_pend_next)
  );

endmodule

// File: tb/tb_huffman_byte_packer.sv
// Directed bench for huffman_byte_packer: byte order, stuffing, padding, done timing, reset.
module tb_huffman_byte_packer;
  import huffman_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  HuffmanBus_t in_bus;
  logic        in_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_done;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int done_cnt = 0;
  int last_hs_cyc = 0;
  int last_done_cyc = 0;
  int last_acc_cyc = 0;
  logic       stall_q = 1'b0;
  logic [7:0] stall_data = 8'h00;
  logic [7:0] cap[$];
  logic [7:0] expq[$];

  huffman_byte_packer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_bus    (in_bus),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_done  (out_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_bytes(input string tag);
    check({tag, "_count"}, 64'(cap.size()), 64'(expq.size()));
    for (int i = 0; i < expq.size(); i++) begin
      check($sformatf("%s_b%0d", tag, i), (i < cap.size()) ? {56'h0, cap[i]} : 64'hx, {56'h0, expq[i]});
    end
  endtask

  // Present one beat at a negedge, wait (bounded) for in_ready, complete the handshake.
  task automatic send(input int sz, input logic [35:0] cd, input logic v, input logic d, output int waits);
    int g;
    g = 0;
    in_bus.data.size = SIZE_W'(sz);
    in_bus.data.code = cd;
    in_bus.valid     = v;
    in_bus.done      = d;
    while (!in_ready && g < 100) begin
      @(negedge clk);
      g++;
    end
    check("send_ready", {63'h0, in_ready}, 64'h1);
    waits = g;
    @(posedge clk);
    @(negedge clk);
    in_bus.valid = 1'b0;
    in_bus.done  = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int base);
    int g;
    g = 0;
    while (done_cnt == base && g < 100) begin
      @(negedge clk);
      g++;
    end
    check(tag, 64'(done_cnt - base), 64'h1);
  endtask

  // Monitor: capture transferred bytes, count done pulses, check hold-while-stalled.
  always @(posedge clk) begin
    if (!rst_n) begin
      stall_q = 1'b0;
    end else begin
      if (stall_q) begin
        check("stall_valid", {63'h0, out_valid}, 64'h1);
        check("stall_data", {56'h0, out_data}, {56'h0, stall_data});
      end
      if (in_bus.valid) begin
        check("size_legal", {63'h0, (in_bus.data.size <= CODE_W_S)}, 64'h1);
      end
      if (out_valid && out_ready) begin
        cap.push_back(out_data);
        last_hs_cyc = cyc;
        $display("byte cyc=%0d data=%02h", cyc, out_data);
      end
      if (out_done) begin
        done_cnt++;
        last_done_cyc = cyc;
        $display("done cyc=%0d", cyc);
      end
      if (in_ready && (in_bus.valid || in_bus.done)) begin
        last_acc_cyc = cyc;
      end
      stall_q    = out_valid && !out_ready;
      stall_data = out_data;
    end
    cyc++;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int w;
    int base;
    int acc_c;

    rst_n     = 1'b0;
    in_bus    = '0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_out_valid", {63'h0, out_valid}, 64'h0);
    check("rst_out_done", {63'h0, out_done}, 64'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", {63'h0, in_ready}, 64'h1);

    // Two nibbles form 0xA5, one cycle after the second accept.
    cap.delete();
    base = done_cnt;
    send(4, 36'hA, 1'b1, 1'b0, w);
    send(4, 36'h5, 1'b1, 1'b0, w);
    acc_c = last_acc_cyc;
    repeat (4) @(negedge clk);
    expq = '{8'hA5};
    check_bytes("t1");
    check("t1_latency", 64'(last_hs_cyc - acc_c), 64'h1);
    check("t1_no_done", 64'(done_cnt - base), 64'h0);

    // 0xFF gets a stuffed 0x00 before the next byte; input never stalls.
    cap.delete();
    send(8, 36'hFF, 1'b1, 1'b0, w);
    check("t2_wait1", 64'(w), 64'h0);
    send(8, 36'h12, 1'b1, 1'b0, w);
    check("t2_wait2", 64'(w), 64'h0);
    repeat (5) @(negedge clk);
    expq = '{8'hFF, 8'h00, 8'h12};
    check_bytes("t2");
    check("t2_in_ready", {63'h0, in_ready}, 64'h1);

    // Code with done: 010 padded with ones -> 0x5F, done one cycle after its transfer.
    cap.delete();
    base = done_cnt;
    send(3, 36'h2, 1'b1, 1'b1, w);
    wait_done("t3_done_seen", base);
    check("t3_in_ready", {63'h0, in_ready}, 64'h1);
    expq = '{8'h5F};
    check_bytes("t3");
    check("t3_done_lat", 64'(last_done_cyc - last_hs_cyc), 64'h1);
    repeat (4) @(negedge clk);
    check("t3_done_once", 64'(done_cnt - base), 64'h1);

    // Full-width codes under backpressure: 76 bits of ones then zeros, padded to 80.
    cap.delete();
    base = done_cnt;
    out_ready = 1'b0;
    send(36, 36'hF_FFFF_FFFF, 1'b1, 1'b0, w);
    check("t4_ready_drop", {63'h0, in_ready}, 64'h0);
    check("t4_valid", {63'h0, out_valid}, 64'h1);
    check("t4_data", {56'h0, out_data}, 64'hFF);
    repeat (3) @(negedge clk);
    out_ready = 1'b1;
    send(36, 36'hF_FFFF_FFFF, 1'b1, 1'b0, w);
    send(4, 36'h0, 1'b1, 1'b0, w);
    send(0, 36'h0, 1'b0, 1'b1, w);
    wait_done("t4_done_seen", base);
    expq.delete();
    for (int i = 0; i < 9; i++) begin
      expq.push_back(8'hFF);
      expq.push_back(8'h00);
    end
    expq.push_back(8'h0F);
    check_bytes("t4");

    // Done alone on an empty accumulator: no bytes, done two cycles after the accept.
    cap.delete();
    base = done_cnt;
    send(0, 36'h0, 1'b0, 1'b1, w);
    acc_c = last_acc_cyc;
    wait_done("t5_done_seen", base);
    check("t5_no_bytes", 64'(cap.size()), 64'h0);
    check("t5_done_lat", 64'(last_done_cyc - acc_c), 64'h2);
    repeat (5) @(negedge clk);
    check("t5_done_once", 64'(done_cnt - base), 64'h1);

    // size=0 beats are no-ops; code bits above size are ignored.
    cap.delete();
    send(0, 36'hF_FFFF_FFFF, 1'b1, 1'b0, w);
    check("t6_zero_novalid", {63'h0, out_valid}, 64'h0);
    send(4, 36'hF_FFFF_FFFC, 1'b1, 1'b0, w);
    check("t6_nibble_novalid", {63'h0, out_valid}, 64'h0);
    send(0, 36'h0_0000_1234, 1'b1, 1'b0, w);
    check("t6_zero2_novalid", {63'h0, out_valid}, 64'h0);
    send(4, 36'hA_BCDE_F013, 1'b1, 1'b0, w);
    repeat (4) @(negedge clk);
    expq = '{8'hC3};
    check_bytes("t6");

    // Reset mid-scan with 20 bits held and a stuff byte owed.
    cap.delete();
    base = done_cnt;
    out_ready = 1'b0;
    send(8, 36'hFF, 1'b1, 1'b0, w);
    send(20, 36'hABCDE, 1'b1, 1'b0, w);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("t7_pre_valid", {63'h0, out_valid}, 64'h1);
    check("t7_pre_stuff", {56'h0, out_data}, 64'h00);
    rst_n = 1'b0;
    #1;
    check("t7_rst_valid", {63'h0, out_valid}, 64'h0);
    check("t7_rst_done", {63'h0, out_done}, 64'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    cap.delete();
    send(8, 36'h3C, 1'b1, 1'b0, w);
    repeat (6) @(negedge clk);
    expq = '{8'h3C};
    check_bytes("t7");
    check("t7_no_done", 64'(done_cnt - base), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
